// File: rtl/ysyx_23060187_mem_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter and the LSU store-mask logic.
package ysyx_23060187_mem_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Which requester owns the in-flight (or most recent) transaction
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } mem_owner_e;

  // Byte masks for sb/sh/sw on a 32-bit data path
  localparam logic [3:0] MASK_B = 4'h1;
  localparam logic [3:0] MASK_H = 4'h3;
  localparam logic [3:0] MASK_W = 4'hF;

endpackage

// File: rtl/ysyx_23060187_wdog_cnt.sv
// Transaction watchdog: counts busy cycles and flags expiry once TIMEOUT is reached.
// TIMEOUT = 0 disables the watchdog entirely.
module ysyx_23060187_wdog_cnt
  import ysyx_23060187_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          Enabled = (TIMEOUT != 0);
  // Expire while the counter is about to step onto TIMEOUT
  localparam logic [CntW-1:0] LastCnt = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CntW-1:0] cnt_q;

  // Busy-cycle counter, restarted on every accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expire_o = Enabled && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/ysyx_23060187_mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One outstanding transaction, round-robin on ties, registered request fields,
// response routed back to the owner, watchdog abort with sticky error flag.
module ysyx_23060187_mem_arbiter
  import ysyx_23060187_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  // load/store unit
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  // memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  mem_state_e state_q, state_d;
  mem_owner_e owner_q, owner_d;

  logic grant_ifu, grant_lsu, accept;
  logic resp_fire, timeout_fire, done;
  logic wdog_en, wdog_expire;
  logic [DATA_W-1:0] done_data;

  logic                mem_wen_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_wmask_q;
  logic                ifu_resp_valid_q, lsu_resp_valid_q;
  logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic                err_q;

  // Grant in IDLE only; on a tie the requester that did not own the last transaction wins
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (owner_q == OWN_LSU) grant_ifu = 1'b1;
        else                    grant_lsu = 1'b1;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign accept        = grant_ifu | grant_lsu;

  // Next state, owner, and completion strobes
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    resp_fire    = 1'b0;
    timeout_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          owner_d = grant_ifu ? OWN_IFU : OWN_LSU;
        end
      end
      REQ: begin
        if (wdog_expire) begin
          state_d      = IDLE;
          timeout_fire = 1'b1;
        end else if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // A real response in the expiry cycle still wins over the abort
        if (mem_resp_valid) begin
          state_d   = IDLE;
          resp_fire = 1'b1;
        end else if (wdog_expire) begin
          state_d      = IDLE;
          timeout_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and owner registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LSU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Latch the granted request; fields stay put until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else if (grant_lsu) begin
      mem_wen_q   <= lsu_wen;
      mem_addr_q  <= lsu_addr;
      mem_wdata_q <= lsu_wdata;
      mem_wmask_q <= lsu_wmask;
    end else if (grant_ifu) begin
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= ifu_addr;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end
  end

  assign done      = resp_fire | timeout_fire;
  assign done_data = resp_fire ? mem_rdata : '0;

  // Route completion to the owner; the other side keeps its last read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
      err_q            <= 1'b0;
    end else begin
      ifu_resp_valid_q <= done && (owner_q == OWN_IFU);
      lsu_resp_valid_q <= done && (owner_q == OWN_LSU);
      if (done && owner_q == OWN_IFU) ifu_rdata_q <= done_data;
      if (done && owner_q == OWN_LSU) lsu_rdata_q <= done_data;
      if (timeout_fire) err_q <= 1'b1;
    end
  end

  assign wdog_en = (state_q == REQ) || (state_q == RESP);

  ysyx_23060187_wdog_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (accept),
    .en_i    (wdog_en),
    .expire_o(wdog_expire)
  );

  assign mem_req_valid  = (state_q == REQ);
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign err            = err_q;

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: stimulus pushes expected responses
// (data and arrival cycle), a negedge monitor pops and compares them.
module tb_ysyx_23060187_mem_arbiter;
  import ysyx_23060187_mem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr = '0;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0, lsu_rdata;
  logic [3:0]    lsu_wmask = '0;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  ysyx_23060187_mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .err           (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t ifu_q[$];
  exp_t lsu_q[$];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory model: ready after ready_delay REQ cycles, response the following cycle
  int unsigned   ready_delay = 0;
  int unsigned   wait_cnt    = 0;
  bit            resp_en     = 1'b1;
  bit            resp_pend   = 1'b0;
  bit            inject      = 1'b0;
  logic [DW-1:0] resp_data   = '0;

  initial begin : mem_model
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (resp_pend || inject) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = resp_pend ? resp_data : 32'hDEAD_BEEF;
      end
      resp_pend = 1'b0;
      if (mem_req_valid) begin
        if (wait_cnt >= ready_delay) begin
          mem_req_ready = 1'b1;
          wait_cnt      = 0;
          resp_pend     = resp_en;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every resp_valid pulse must match the oldest expectation for that side
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ifu_resp_valid) begin
      if (ifu_q.size() == 0) chk("ifu_resp_unexpected", ifu_resp_valid, 1'b0);
      else begin
        e = ifu_q.pop_front();
        chk("ifu_rdata", ifu_rdata, e.rdata);
        chk("ifu_resp_cycle", cyc, e.cyc);
      end
    end
    if (lsu_resp_valid) begin
      if (lsu_q.size() == 0) chk("lsu_resp_unexpected", lsu_resp_valid, 1'b0);
      else begin
        e = lsu_q.pop_front();
        chk("lsu_rdata", lsu_rdata, e.rdata);
        chk("lsu_resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ifu_req_ready"}, ifu_req_ready, 0);
    chk({tag, "_lsu_req_ready"}, lsu_req_ready, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_ifu_resp_valid"}, ifu_resp_valid, 0);
    chk({tag, "_lsu_resp_valid"}, lsu_resp_valid, 0);
    chk({tag, "_ifu_rdata"}, ifu_rdata, 0);
    chk({tag, "_lsu_rdata"}, lsu_rdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && (ifu_q.size() + lsu_q.size()) != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk({tag, "_drained"}, ifu_q.size() + lsu_q.size(), 0);
  endtask

  // One transaction from one side; tmo = memory never answers
  task automatic issue(input string tag, input bit lsu, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int unsigned delay, input logic [31:0] data, input bit tmo);
    int   t;
    bit   acc;
    int   last;
    exp_t e;
    t           = 0;
    acc         = 1'b0;
    ready_delay = tmo ? 1000 : delay;
    resp_data   = data;
    resp_en     = 1'b1;
    @(posedge clk);
    #1;
    if (lsu) begin
      lsu_req_valid = 1'b1;
      lsu_wen       = wen;
      lsu_addr      = addr;
      lsu_wdata     = wdata;
      lsu_wmask     = wmask;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr      = addr;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (lsu ? lsu_req_ready : ifu_req_ready) begin
        acc = 1'b1;
        t   = cyc;
      end
      @(posedge clk);
      #1;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk({tag, "_accepted"}, acc, 1);
    if (!acc) return;
    e.rdata = tmo ? 32'h0 : data;
    e.cyc   = t + (tmo ? int'(TO) + 1 : int'(delay) + 3);
    if (lsu) lsu_q.push_back(e);
    else     ifu_q.push_back(e);
    // Request fields must hold for every REQ cycle
    last = tmo ? int'(TO) - 2 : int'(delay);
    for (int k = 0; k <= last; k++) begin
      #1;
      chk({tag, "_mem_req_valid"}, mem_req_valid, 1);
      chk({tag, "_mem_addr"}, mem_addr, addr);
      chk({tag, "_mem_wen"}, mem_wen, lsu ? wen : 1'b0);
      chk({tag, "_mem_wmask"}, mem_wmask, lsu ? wmask : 4'h0);
      if (lsu) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
      @(posedge clk);
      #1;
    end
    wait_drain(tag);
  endtask

  // Both requesters held valid: grants must go IFU, LSU, IFU, LSU, 3 cycles apart
  task automatic test_tie();
    bit   acc;
    bit   side;
    int   t;
    int   prev;
    exp_t e;
    prev        = 0;
    ready_delay = 0;
    resp_en     = 1'b1;
    resp_data   = 32'h1234_5678;
    @(posedge clk);
    #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_0200;
    lsu_wmask     = 4'h0;
    for (int n = 0; n < 4; n++) begin
      acc  = 1'b0;
      side = 1'b0;
      t    = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
        #1;
        if (ifu_req_ready || lsu_req_ready) begin
          acc  = 1'b1;
          side = lsu_req_ready;
          t    = cyc;
          chk("tie_single_grant", ifu_req_ready & lsu_req_ready, 0);
        end
        @(posedge clk);
        #1;
      end
      chk("tie_accepted", acc, 1);
      chk("tie_grant_order", side, n % 2);
      if (n > 0) chk("tie_accept_spacing", t - prev, 3);
      prev    = t;
      e.rdata = resp_data;
      e.cyc   = t + 3;
      if (side) lsu_q.push_back(e);
      else      ifu_q.push_back(e);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    wait_drain("tie");
  endtask

  // Reset while in RESP: silent drop, reset values at once, stray response ignored
  task automatic test_reset_mid();
    bit acc;
    acc         = 1'b0;
    ready_delay = 0;
    resp_en     = 1'b0;
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_0040;
    lsu_wmask     = 4'h0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (lsu_req_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    lsu_req_valid = 1'b0;
    chk("rstmid_accepted", acc, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk) inject = 1'b1;
    @(negedge clk) inject = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rstmid_idle_req_valid", mem_req_valid, 0);
    resp_en = 1'b1;
    issue("rstmid_next", 1'b1, 1'b0, 32'h8000_0044, 32'h0, MASK_W, 0, 32'h0BAD_F00D, 1'b0);
  endtask

  initial begin : stimulus
    // Reset values, readies must stay low even with requests pending
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals("reset");
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    test_tie();

    issue("ifu_fetch", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0010_0093, 1'b0);

    issue("lsu_store", 1'b1, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, MASK_H, 4, 32'h5555_0000, 1'b0);
    chk("ifu_rdata_hold", ifu_rdata, 32'h0010_0093);

    // Spurious memory response while idle
    @(negedge clk) inject = 1'b1;
    @(negedge clk) inject = 1'b0;
    #3;
    chk("spurious_mem_req_valid", mem_req_valid, 0);
    repeat (3) @(posedge clk);
    issue("after_spurious", 1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 32'h0000_0513, 1'b0);

    test_reset_mid();

    // Watchdog abort: zero data to the owner, sticky err
    issue("timeout", 1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b1);
    chk("timeout_err", err, 1);
    chk("timeout_mem_req_valid", mem_req_valid, 0);
    issue("post_timeout", 1'b1, 1'b0, 32'h8000_0020, 32'h0, MASK_W, 0, 32'h7777_8888, 1'b0);
    chk("err_sticky", err, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : time_limit
    #200000;
    $display("FAIL time_limit: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
